// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl
//   Register-to-register (or immediate-to-register) transfer sequencer for a
//   shared 8-bit bus. A request is accepted only in IDLE. The transfer then
//   runs DRIVE -> LATCH -> DONE -> IDLE. The source is enabled for DRIVE and
//   LATCH. The destination write strobe is raised in LATCH only, so the source
//   is always driving whenever a register is loading.
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   req              transfer request (sampled in IDLE only)
//   src, dst         source / destination register index
//   imm_en, imm      use immediate value imm instead of register src
//   bus_in           bus value as observed by the controller
//   rd, wr           one-hot read / write strobes to the bus registers
//   bus_out, bus_oe  immediate drive value and its output enable
//   busy             transfer in progress
//   done             one-cycle pulse when a transfer completes
//   err              one-cycle pulse when a request is rejected (src == dst)
//   last_val         bus value captured by the last completed transfer
module bus_xfer_ctrl #(
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req,
    input  logic [AW-1:0]   src,
    input  logic [AW-1:0]   dst,
    input  logic            imm_en,
    input  logic [7:0]      imm,
    input  logic [7:0]      bus_in,
    output logic [NREG-1:0] rd,
    output logic [NREG-1:0] wr,
    output logic [7:0]      bus_out,
    output logic            bus_oe,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [7:0]      last_val
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]      state_q,    state_d;
    logic [AW-1:0]   src_q,      src_d;
    logic [AW-1:0]   dst_q,      dst_d;
    logic            imm_en_q,   imm_en_d;
    logic [7:0]      imm_q,      imm_d;
    logic [NREG-1:0] rd_q,       rd_d;
    logic [NREG-1:0] wr_q,       wr_d;
    logic [7:0]      bus_out_q,  bus_out_d;
    logic            bus_oe_q,   bus_oe_d;
    logic            busy_q,     busy_d;
    logic            done_q,     done_d;
    logic            err_q,      err_d;
    logic [7:0]      last_val_q, last_val_d;

    // Index to one-hot strobe vector.
    function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] idx);
        logic [NREG-1:0] oh;
        oh = '0;
        for (int i = 0; i < NREG; i++) begin
            oh[i] = (idx == AW'(i));
        end
        return oh;
    endfunction

    // Next-state and next-output logic. Outputs are computed one state ahead
    // so that every output comes straight from a flop.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        imm_en_d   = imm_en_q;
        imm_d      = imm_q;
        rd_d       = '0;
        wr_d       = '0;
        bus_out_d  = 8'h00;
        bus_oe_d   = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        last_val_d = last_val_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (!imm_en && (src == dst)) begin
                        // Self-copy is rejected; remain idle and flag it.
                        err_d = 1'b1;
                    end else begin
                        src_d    = src;
                        dst_d    = dst;
                        imm_en_d = imm_en;
                        imm_d    = imm;
                        state_d  = S_DRIVE;
                        busy_d   = 1'b1;
                        if (imm_en) begin
                            bus_oe_d  = 1'b1;
                            bus_out_d = imm;
                        end else begin
                            rd_d = onehot(src);
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRIVE: begin
                // Keep the source on the bus and add the destination load.
                state_d = S_LATCH;
                busy_d  = 1'b1;
                wr_d    = onehot(dst_q);
                if (imm_en_q) begin
                    bus_oe_d  = 1'b1;
                    bus_out_d = imm_q;
                end else begin
                    rd_d = onehot(src_q);
                end
            end
            S_LATCH: begin
                // Bus is stable here: source and destination both enabled.
                state_d    = S_DONE;
                busy_d     = 1'b1;
                done_d     = 1'b1;
                last_val_d = bus_in;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            imm_en_q   <= 1'b0;
            imm_q      <= 8'h00;
            rd_q       <= '0;
            wr_q       <= '0;
            bus_out_q  <= 8'h00;
            bus_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            last_val_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            imm_en_q   <= imm_en_d;
            imm_q      <= imm_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            bus_out_q  <= bus_out_d;
            bus_oe_q   <= bus_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            last_val_q <= last_val_d;
        end
    end

    assign rd       = rd_q;
    assign wr       = wr_q;
    assign bus_out  = bus_out_q;
    assign bus_oe   = bus_oe_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign last_val = last_val_q;

endmodule
